// File: rtl/ifmap_loader_pkg.sv
// Shared types and constants for the ifmap loader and the NoC packet path.
package ifmap_loader_pkg;

  typedef enum logic [1:0] {
    WK_START = 2'd0,
    WK_PIXEL = 2'd1,
    WK_DONE  = 2'd2
  } wr_kind_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SEND_START = 3'd1,
    S_WAIT_ROW   = 3'd2,
    S_SEND_PIX   = 3'd3,
    S_SEND_DONE  = 3'd4
  } loader_state_t;

  // Packet field positions shared with the router path
  localparam int NOC_ADDR_HI   = 32;
  localparam int NOC_ADDR_LO   = 29;
  localparam int NOC_OPCODE_HI = 28;
  localparam int NOC_OPCODE_LO = 25;
  localparam int NOC_DATA_HI   = 24;
  localparam int NOC_DATA_LO   = 0;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ifmap_loader_if.sv
// Row input and write-beat output bundle of the ifmap loader.
interface ifmap_loader_if #(
  parameter int DEPTH_I    = 25,
  parameter int WIDTH_ADDR = 12,
  parameter int WIDTH_TS   = 2
) ();
  import ifmap_loader_pkg::*;

  logic                  row_valid;
  logic [DEPTH_I-1:0]    row_data;
  logic                  row_ready;
  logic                  wr_valid;
  logic                  wr_ready;
  wr_kind_t              wr_kind;
  logic [WIDTH_TS-1:0]   wr_ts;
  logic [WIDTH_ADDR-1:0] wr_addr;
  logic                  wr_data;

  modport master (
    input  row_valid, row_data, wr_ready,
    output row_ready, wr_valid, wr_kind, wr_ts, wr_addr, wr_data
  );

  modport slave (
    output row_valid, row_data, wr_ready,
    input  row_ready, wr_valid, wr_kind, wr_ts, wr_addr, wr_data
  );
endinterface

// File: rtl/ifmap_loader_addr_gen.sv
// Column/row/timestep counters plus the running linear pixel address.
module ifmap_loader_addr_gen
  import ifmap_loader_pkg::*;
#(
  parameter int DEPTH_I    = 25,
  parameter int NUM_TS     = 2,
  parameter int WIDTH_ADDR = 12,
  parameter int WIDTH_TS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  step_i,
  output logic [WIDTH_ADDR-1:0] addr_o,
  output logic [WIDTH_TS-1:0]   ts_o,
  output logic                  last_col_o,
  output logic                  last_row_o,
  output logic                  last_ts_o
);

  localparam int CW = cnt_w(DEPTH_I);

  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [WIDTH_TS-1:0]   ts_q, ts_d;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;

  assign last_col_o = (col_q == CW'(DEPTH_I - 1));
  assign last_row_o = (row_q == CW'(DEPTH_I - 1));
  assign last_ts_o  = (ts_q == WIDTH_TS'(NUM_TS));
  assign addr_o     = addr_q;
  assign ts_o       = ts_q;

  // Address advances by one per pixel and wraps to 0 at each timestep end
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ts_d   = ts_q;
    addr_d = addr_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      ts_d   = WIDTH_TS'(1);
      addr_d = '0;
    end else if (step_i) begin
      if (last_col_o) begin
        col_d = '0;
        if (last_row_o) begin
          row_d  = '0;
          addr_d = '0;
          if (!last_ts_o) ts_d = ts_q + WIDTH_TS'(1);
        end else begin
          row_d  = row_q + CW'(1);
          addr_d = addr_q + WIDTH_ADDR'(1);
        end
      end else begin
        col_d  = col_q + CW'(1);
        addr_d = addr_q + WIDTH_ADDR'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      ts_q   <= WIDTH_TS'(1);
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      ts_q   <= ts_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/ifmap_loader.sv
// Serialises spike rows into START / PIXEL / DONE write beats for the imem load port.
module ifmap_loader
  import ifmap_loader_pkg::*;
#(
  parameter int DEPTH_I    = 25,
  parameter int NUM_TS     = 2,
  parameter int WIDTH_ADDR = 12,
  parameter int WIDTH_TS   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go_i,
  ifmap_loader_if.master bus,
  output logic           busy_o,
  output logic           done_o
);

  if (DEPTH_I * DEPTH_I > (1 << WIDTH_ADDR)) begin : g_bad_addr_w
    $error("ifmap_loader: WIDTH_ADDR cannot hold DEPTH_I*DEPTH_I addresses");
  end
  if (NUM_TS >= (1 << WIDTH_TS)) begin : g_bad_ts_w
    $error("ifmap_loader: WIDTH_TS cannot hold NUM_TS");
  end

  loader_state_t      state_q;
  logic               wr_valid_q;
  wr_kind_t           wr_kind_q;
  logic               wr_data_q;
  logic               row_ready_q;
  logic               busy_q;
  logic               done_q;
  logic [DEPTH_I-1:0] sh_q;

  logic accept, pix_step, start_run;
  logic last_col, last_row, last_ts;

  assign accept    = wr_valid_q && bus.wr_ready;
  assign pix_step  = (state_q == S_SEND_PIX) && accept;
  // go coinciding with the done pulse must not launch a new run
  assign start_run = (state_q == S_IDLE) && go_i && !done_q;

  ifmap_loader_addr_gen #(
    .DEPTH_I   (DEPTH_I),
    .NUM_TS    (NUM_TS),
    .WIDTH_ADDR(WIDTH_ADDR),
    .WIDTH_TS  (WIDTH_TS)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_run),
    .step_i    (pix_step),
    .addr_o    (bus.wr_addr),
    .ts_o      (bus.wr_ts),
    .last_col_o(last_col),
    .last_row_o(last_row),
    .last_ts_o (last_ts)
  );

  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_kind   = wr_kind_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.row_ready = row_ready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_valid_q  <= 1'b0;
      wr_kind_q   <= WK_START;
      wr_data_q   <= 1'b0;
      row_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sh_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_run) begin
            state_q    <= S_SEND_START;
            wr_valid_q <= 1'b1;
            wr_kind_q  <= WK_START;
            wr_data_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_SEND_START: begin
          if (accept) begin
            state_q     <= S_WAIT_ROW;
            wr_valid_q  <= 1'b0;
            row_ready_q <= 1'b1;
          end
        end
        S_WAIT_ROW: begin
          if (bus.row_valid && row_ready_q) begin
            state_q     <= S_SEND_PIX;
            row_ready_q <= 1'b0;
            wr_valid_q  <= 1'b1;
            wr_kind_q   <= WK_PIXEL;
            wr_data_q   <= bus.row_data[0];
            sh_q        <= bus.row_data >> 1;
          end
        end
        S_SEND_PIX: begin
          if (accept) begin
            if (!last_col) begin
              wr_data_q <= sh_q[0];
              sh_q      <= sh_q >> 1;
            end else if (last_row && last_ts) begin
              state_q   <= S_SEND_DONE;
              wr_kind_q <= WK_DONE;
              wr_data_q <= 1'b0;
            end else begin
              state_q     <= S_WAIT_ROW;
              wr_valid_q  <= 1'b0;
              wr_data_q   <= 1'b0;
              row_ready_q <= 1'b1;
            end
          end
        end
        S_SEND_DONE: begin
          if (accept) begin
            state_q    <= S_IDLE;
            wr_valid_q <= 1'b0;
            wr_kind_q  <= WK_START;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_loader.sv
// Scoreboard bench for ifmap_loader: expected beats queued by stimulus, popped by a monitor.
module tb_ifmap_loader;
  import ifmap_loader_pkg::*;

  localparam int D   = 25;
  localparam int NTS = 2;
  localparam int WA  = 12;
  localparam int WT  = 2;

  logic clk = 1'b0;
  logic rst;
  logic go;
  logic busy, done;

  ifmap_loader_if #(.DEPTH_I(D), .WIDTH_ADDR(WA), .WIDTH_TS(WT)) bus ();

  ifmap_loader #(.DEPTH_I(D), .NUM_TS(NTS), .WIDTH_ADDR(WA), .WIDTH_TS(WT)) dut (
    .clk   (clk),
    .rst   (rst),
    .go_i  (go),
    .bus   (bus.master),
    .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    kind;
    logic [WT-1:0] ts;
    logic [WA-1:0] addr;
    logic          data;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp   = 0;
  int    n_fail  = 0;
  int    n_beats = 0;
  int    n_done  = 0;
  int    rdy_mode = 0;

  beat_t mon_act, mon_held, mon_exp;
  logic  mon_held_v = 1'b0;
  logic  mon_pend_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int k, input int ts, input int a, input logic d);
    beat_t b;
    b.kind = 2'(k);
    b.ts   = WT'(ts);
    b.addr = WA'(a);
    b.data = d;
    return b;
  endfunction

  function automatic logic [D-1:0] rowpat(input int mode, input int ts, input int r);
    if (mode == 0) return '0;
    if (ts == 1 && r == 0) return 25'h1000001;
    return D'((r * 32'h00ABCDE5) ^ (ts * 32'h00001357) ^ 32'h000F0F0F);
  endfunction

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) bus.wr_ready = 1'b1;
      else bus.wr_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: stall stability, done timing, and scoreboard pops
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_held_v    = 1'b0;
        mon_pend_done = 1'b0;
      end else begin
        mon_act = {bus.wr_kind, bus.wr_ts, bus.wr_addr, bus.wr_data};
        if (mon_held_v) begin
          chk("stall_valid", 32'(bus.wr_valid), 32'd1);
          chk("stall_hold", 32'(mon_act), 32'(mon_held));
        end
        if (done || mon_pend_done) begin
          chk("done_pulse", 32'(done), 32'(mon_pend_done));
          if (done) n_done++;
        end
        mon_pend_done = bus.wr_valid && bus.wr_ready && (bus.wr_kind == WK_DONE);
        mon_held_v    = bus.wr_valid && !bus.wr_ready;
        mon_held      = mon_act;
        if (bus.wr_valid && bus.wr_ready) begin
          n_beats++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h with nothing expected at %0t", mon_act, $time);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_exp.kind == 2'(WK_DONE)) mon_act.ts = mon_exp.ts;
            chk("beat", 32'(mon_act), 32'(mon_exp));
          end
        end
      end
    end
  end

  task automatic run(input int mode, input int hold_row, input bit abort, input bit go_mid,
                     input bit go_done);
    logic [D-1:0] rp;
    int nd0;
    bit found;
    nd0 = n_done;
    exp_q.push_back(mk(0, 1, 0, 1'b0));
    for (int t = 1; t <= NTS; t++)
      for (int r = 0; r < D; r++) begin
        rp = rowpat(mode, t, r);
        for (int c = 0; c < D; c++) exp_q.push_back(mk(1, t, r * D + c, rp[c]));
      end
    exp_q.push_back(mk(2, NTS, 0, 1'b0));

    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    chk("start_latency", 32'(bus.wr_valid), 32'd1);

    for (int t = 1; t <= NTS; t++)
      for (int r = 0; r < D; r++) begin
        @(negedge clk);
        for (int i = 0; i < 400 && !bus.row_ready; i++) @(negedge clk);
        if (!bus.row_ready) begin
          chk("row_ready_timeout", 32'(bus.row_ready), 32'd1);
          return;
        end
        if (t == 1 && r == hold_row)
          repeat (10) begin
            chk("hold_row_ready", 32'(bus.row_ready), 32'd1);
            chk("hold_no_beat", 32'(bus.wr_valid), 32'd0);
            @(negedge clk);
          end
        bus.row_valid = 1'b1;
        bus.row_data  = rowpat(mode, t, r);
        @(posedge clk);
        #1 bus.row_valid = 1'b0;
        chk("pix_latency", 32'({bus.wr_valid, bus.wr_kind}), 32'({1'b1, WK_PIXEL}));
        if (go_mid && t == 1 && r == 4) begin
          go = 1'b1;
          @(posedge clk);
          #1 go = 1'b0;
        end
        if (abort && t == 2 && r == 12) begin
          found = 1'b0;
          for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.wr_valid && bus.wr_addr == WA'(300) && bus.wr_ts == WT'(2)) found = 1'b1;
          end
          chk("abort_reached", 32'(found), 32'd1);
          #2 rst = 1'b1;
          #1;
          chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_row_ready", 32'(bus.row_ready), 32'd0);
          chk("rst_beat", 32'({bus.wr_kind, bus.wr_ts, bus.wr_addr, bus.wr_data}),
              32'(mk(0, 1, 0, 1'b0)));
          repeat (2) @(posedge clk);
          @(negedge clk);
          #1 rst = 1'b0;
          exp_q.delete();
          repeat (5) @(negedge clk);
          chk("rst_no_done", 32'(n_done), 32'(nd0));
          chk("rst_idle", 32'(busy), 32'd0);
          return;
        end
      end

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("done_seen", 32'(found), 32'd1);
    if (go_done) begin
      go = 1'b1;
      @(posedge clk);
      #1 go = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_once", 32'(n_done - nd0), 32'd1);
  endtask

  int b0;

  initial begin
    rst = 1'b1;
    go = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    #1;
    chk("reset_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_row_ready", 32'(bus.row_ready), 32'd0);
    chk("reset_beat", 32'({bus.wr_kind, bus.wr_ts, bus.wr_addr, bus.wr_data}),
        32'(mk(0, 1, 0, 1'b0)));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    b0 = n_beats;
    run(0, -1, 1'b0, 1'b0, 1'b0);
    chk("beat_count_zero_rows", 32'(n_beats - b0), 32'd1252);

    run(1, 3, 1'b0, 1'b0, 1'b0);

    rdy_mode = 1;
    b0 = n_beats;
    run(0, -1, 1'b0, 1'b0, 1'b0);
    chk("beat_count_stalled", 32'(n_beats - b0), 32'd1252);
    rdy_mode = 0;

    run(1, -1, 1'b1, 1'b0, 1'b0);

    b0 = n_beats;
    run(0, -1, 1'b0, 1'b1, 1'b1);
    chk("beat_count_go_ignored", 32'(n_beats - b0), 32'd1252);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifmap_loader.md
Name: ifmap_loader

Overview:
- Clocked front-end that feeds the input memory (imem) load port.
- Accepts one 25-pixel binary spike row per handshake and serialises it into per-pixel write beats tagged with timestep and linear address.
- Brackets the whole transfer with a START beat and a DONE beat; covers NUM_TS timesteps of a DEPTH_I x DEPTH_I ifmap.
- Sits directly upstream of imem; a CSP-side shim converts its beats into imem's load_start / timestep / ifmap_addr / ifmap_data / load_done sends.

Parameters:
- DEPTH_I, 25, ifmap side length: pixels per row and rows per timestep.
- NUM_TS, 2, number of timesteps loaded per run; timesteps are numbered 1..NUM_TS.
- WIDTH_ADDR, 12, width of the linear pixel address.
- WIDTH_TS, 2, width of the timestep tag.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- go, in, 1, start request; sampled only in IDLE.
- row_valid, in, 1, upstream row available.
- row_data, in, DEPTH_I, spike row; bit c is column c.
- row_ready, out, 1, loader can accept a row.
- wr_valid, out, 1, write beat valid.
- wr_ready, in, 1, downstream accepts the beat.
- wr_kind, out, 2, beat type: 0=START, 1=PIXEL, 2=DONE, 3 never driven.
- wr_ts, out, WIDTH_TS, timestep tag of the beat.
- wr_addr, out, WIDTH_ADDR, linear address row*DEPTH_I+col.
- wr_data, out, 1, pixel spike value.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse the cycle after the DONE beat is accepted.

Behaviour:
- Reset: rst=1 forces the following asynchronously:
  - state IDLE; busy, row_ready, wr_valid and done all 0.
  - wr_kind=0, wr_ts=1, wr_addr=0, wr_data=0.
  - row/col counters 0, ts=1, row shift register 0.
- Reset mid-operation drops any in-flight beat or row without completion. No done pulse is produced.
- States are IDLE, SEND_START, WAIT_ROW, SEND_PIX, SEND_DONE, all registered:
  - IDLE: go=1 moves to SEND_START. go in any other state is ignored.
  - SEND_START: wr_valid=1, kind START, ts=1, addr=0, data=0. On wr_valid&&wr_ready go to WAIT_ROW.
  - WAIT_ROW: row_ready=1 (registered by state, no combinational path from wr_ready). On row_valid&&row_ready, capture row_data, set col=0, go to SEND_PIX.
  - SEND_PIX: wr_valid=1, kind PIXEL, data=captured bit col, addr=row*DEPTH_I+col, ts=current ts. Each accept increments col.
    - On the accept of col=DEPTH_I-1 with row<DEPTH_I-1: row++ and go to WAIT_ROW.
    - With row=DEPTH_I-1 and ts<NUM_TS: ts++, row=0, go to WAIT_ROW.
    - With row=DEPTH_I-1 and ts=NUM_TS: go to SEND_DONE.
  - SEND_DONE: wr_valid=1, kind DONE, addr=0, data=0. On accept, assert done for one cycle and return to IDLE.
- Handshake rules:
  - While wr_valid=1 and wr_ready=0, all wr_* outputs hold stable.
  - wr_valid never drops without an accept, except on reset.
  - A beat is transferred every cycle in which wr_valid&&wr_ready.
- Latency and throughput:
  - go to first START beat valid: 1 cycle.
  - Row accept to first PIXEL beat valid: 1 cycle.
  - With wr_ready held at 1, each row takes DEPTH_I+1 cycles (DEPTH_I pixel beats plus 1 WAIT_ROW cycle).
- Address rules:
  - Address restarts at 0 for every timestep. Maximum is DEPTH_I^2-1 = 624.
  - Address is computed incrementally (add 1 per pixel), not by multiplier.
  - Elaboration error if DEPTH_I^2 > 2^WIDTH_ADDR or NUM_TS >= 2^WIDTH_TS.
- Simultaneous events: rst dominates everything. go arriving while done pulses is ignored; a new run needs go in IDLE.

Decomposition:
- snn_pkg holds:
  - wr_kind_t enum (START, PIXEL, DONE).
  - loader_state_t enum.
  - NoC packet field constants shared with the router path: ADDR [32:29], OPCODE [28:25], DATA [24:0].
- One sub-module, ifmap_addr_gen:
  - Holds the col/row/ts counters and the running linear address.
  - Exposes last_col, last_row and last_ts flags to the FSM.

Test Plan:
- Reset then go, wr_ready=1, all-zero rows: START beat (ts=1), then 625 PIXEL beats with addr 0..624 and ts=1, then 625 beats with addr 0..624 and ts=2, then DONE; exactly 1252 beats, done pulses once, busy returns 0.
- Row 0 of ts1 = 25'h1000001: PIXEL addr 0 data 1, addr 24 data 1, addr 1..23 data 0; row 1 starts at addr 25.
- wr_ready toggled pseudo-randomly: every held beat is unchanged across stall cycles; the beat sequence is identical to the first test.
- row_valid withheld 10 cycles in WAIT_ROW: row_ready stays 1, wr_valid stays 0, no beat is emitted until the row arrives.
- rst asserted mid-SEND_PIX at addr 300, ts=2: outputs clear immediately with no done pulse; a new go restarts with START, ts=1, addr 0.
- go pulsed during SEND_PIX and during the done cycle: ignored, with no extra START beat.
